// File: rtl/bp_pkg.sv
// Shared branch-predictor types, counter encodings and index/tag helpers.
// Used by bp_btb and bp_sat_ctr (and the future BHT).
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  // Width-independent part of a table entry; tag/target widths live in the user.
  typedef struct packed {
    logic valid;
    ctr_t ctr;
  } btb_meta_t;

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    if (up) return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    else    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  function automatic logic [63:0] btb_index(input logic [63:0] pc, input int unsigned entries);
    return (pc >> 2) & 64'(entries - 1);
  endfunction

  function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned entries);
    return pc >> ($clog2(entries) + 2);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a 2-bit saturating direction counter.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  assign ctr_next = sat_step(ctr, taken);

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Optional BTB_BYPASS_EN: fetch lookup sees a same-cycle update to its index.
module bp_btb
  import bp_pkg::*;
#(
  parameter int         AWIDTH   = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_f,
  output logic              hit_f,
  output logic              pred_taken,
  output logic [AWIDTH-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [AWIDTH-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [AWIDTH-1:0] upd_target,
  input  logic              flush
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = AWIDTH - IDXW - 2;

  logic [ENTRIES-1:0] valid_reg;
  logic [TAGW-1:0]    tag_reg [ENTRIES];
  logic [1:0]         ctr_reg [ENTRIES];
  logic [AWIDTH-1:0]  tgt_reg [ENTRIES];

  logic [IDXW-1:0]   u_idx, f_idx;
  logic [TAGW-1:0]   u_tag, f_tag;
  logic              u_hit, wr_en, byp;
  logic [1:0]        u_ctr_step;
  btb_meta_t         u_next, f_meta;
  logic [TAGW-1:0]   f_tag_stored;
  logic [AWIDTH-1:0] u_tgt_next, f_tgt;

  assign u_idx = IDXW'(btb_index(64'(upd_pc), ENTRIES));
  assign u_tag = TAGW'(btb_tag(64'(upd_pc), ENTRIES));
  assign f_idx = IDXW'(btb_index(64'(pc_f), ENTRIES));
  assign f_tag = TAGW'(btb_tag(64'(pc_f), ENTRIES));

  assign u_hit = valid_reg[u_idx] && (tag_reg[u_idx] == u_tag);
  // Misses that resolve not-taken are not worth a slot.
  assign wr_en = upd_valid && !flush && (u_hit || upd_taken);

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_reg[u_idx]),
    .taken    (upd_taken),
    .ctr_next (u_ctr_step)
  );

  assign u_next.valid = valid_reg[u_idx] | wr_en;
  assign u_next.ctr   = !wr_en ? ctr_reg[u_idx] : (u_hit ? u_ctr_step : CTR_INIT);
  assign u_tgt_next   = (wr_en && upd_taken) ? upd_target : tgt_reg[u_idx];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          valid_reg[gi] <= 1'b0;
        else if (flush)
          valid_reg[gi] <= 1'b0;
        else if (wr_en && (u_idx == IDXW'(gi)))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Payload has no reset so it can later move into RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_reg[u_idx] <= u_tag;
      ctr_reg[u_idx] <= u_next.ctr;
      tgt_reg[u_idx] <= u_tgt_next;
    end
  end

`ifdef BTB_BYPASS_EN
  assign byp = upd_valid && !flush && (f_idx == u_idx);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    f_meta.valid = valid_reg[f_idx];
    f_meta.ctr   = ctr_reg[f_idx];
    f_tag_stored = tag_reg[f_idx];
    f_tgt        = tgt_reg[f_idx];
    if (byp) begin
      f_meta       = u_next;
      f_tag_stored = wr_en ? u_tag : tag_reg[u_idx];
      f_tgt        = u_tgt_next;
    end
  end

  // Gating with rst keeps the bypass path quiet while reset is held.
  assign hit_f       = rst && f_meta.valid && (f_tag_stored == f_tag);
  assign pred_taken  = hit_f && f_meta.ctr[1];
  assign pred_target = pred_taken ? f_tgt : pc_f + AWIDTH'(4);

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb (ENTRIES=16, AWIDTH=32); expectations hand-computed.
module tb_bp_btb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_f = 32'h8;
  logic        hit_f, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bp_btb dut (
    .clk         (clk),
    .rst         (rst),
    .pc_f        (pc_f),
    .hit_f       (hit_f),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic eh, input logic et, input logic [31:0] etgt);
    pc_f = pc;
    #1;
    chk({tag, ".hit"}, 32'(hit_f), 32'(eh));
    chk({tag, ".taken"}, 32'(pred_taken), 32'(et));
    chk({tag, ".target"}, pred_target, etgt);
    $display("look %-10s pc=0x%0h hit=%0b taken=%0b target=0x%0h", tag, pc, hit_f, pred_taken, pred_target);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    pc_f = 32'h8;
    upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    $display("upd pc=0x%0h taken=%0b target=0x%0h", pc, tk, tgt);
  endtask

  initial begin
    logic [31:0] byp_exp;
    // Reset state
    look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Allocation and lookup
    upd(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Alias at same index, different tag
    look("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
    upd(32'h140, 1'b1, 32'h300);
    look("alias_hit", 32'h140, 1'b1, 1'b1, 32'h300);
    look("evicted", 32'h100, 1'b0, 1'b0, 32'h104);

    // Counter training (re-allocate, ctr=2)
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look("ctr0", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h1C0, 1'b0, 32'h0);   // miss & not-taken: no write
    look("nt_nowr", 32'h100, 1'b1, 1'b0, 32'h104);
    repeat (4) upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // Flush beats a same-cycle allocation
    @(negedge clk);
    upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h500; upd_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0; flush = 1'b0;
    $display("flush with upd pc=0x180");
    look("flush_180", 32'h180, 1'b0, 1'b0, 32'h184);
    look("flush_100", 32'h100, 1'b0, 1'b0, 32'h104);

    // Asynchronous reset mid-cycle
    upd(32'h100, 1'b1, 32'h200);
    look("pre_rst", 32'h100, 1'b1, 1'b1, 32'h200);
    @(posedge clk);
    #2 rst = 1'b0;
    look("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    rst = 1'b1;
    upd(32'h100, 1'b1, 32'h200);
    look("post_rst", 32'h100, 1'b1, 1'b1, 32'h200);

    // Same-cycle lookup and update at the same index
`ifdef BTB_BYPASS_EN
    byp_exp = 32'h240;
`else
    byp_exp = 32'h200;
`endif
    @(negedge clk);
    upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h240; upd_valid = 1'b1;
    look("same_cyc", 32'h100, 1'b1, 1'b1, byp_exp);
    @(negedge clk);
    upd_valid = 1'b0;
    look("after_upd", 32'h100, 1'b1, 1'b1, 32'h240);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
